circular_interp: RTL and testbench

- Point-by-point comparison circular-interpolation engine for a two-axis stepper drive.
- Given start and end points on a circle centred at the origin and a rotation direction, it emits one axis step pulse per clock until the end point is reached, then flags completion.
- Sits between the motion command registers and the X/Y pulse/direction drivers.

---
 rtl/circ_interp_pkg.sv | 8 +
 rtl/circ_step_sel.sv | 34 +++
 rtl/circular_interp.sv | 119 +++++++++++
 tb/tb_circular_interp.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/circ_interp_pkg.sv
// Shared types for the point-by-point circular interpolator.
package circ_interp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {XP, XM, YP, YM} step_t;

  localparam logic DIR_CCW = 1'b1;
  localparam logic DIR_CW  = 1'b0;
endpackage

// File: rtl/circ_step_sel.sv
// Picks the next axis step from quadrant flags, direction and deviation sign.
module circ_step_sel
  import circ_interp_pkg::*;
(
  input  logic  direct,
  input  logic  x_neg,
  input  logic  x_zero,
  input  logic  y_neg,
  input  logic  y_zero,
  input  logic  f_neg,
  output step_t step
);
  logic x_pos, y_pos;

  assign x_pos = !x_neg && !x_zero;
  assign y_pos = !y_neg && !y_zero;

  // Quadrants are tested in order; the final branch also absorbs the origin,
  // which the caller never steps from.
  always_comb begin
    step = XP;
    if (direct == DIR_CCW) begin
      if (x_pos && !y_neg)       step = f_neg ? YP : XM;
      else if (!x_pos && y_pos)  step = f_neg ? XM : YM;
      else if (x_neg && !y_pos)  step = f_neg ? YM : XP;
      else                       step = f_neg ? XP : YP;
    end else begin
      if (!x_neg && y_pos)       step = f_neg ? XP : YM;
      else if (x_neg && !y_neg)  step = f_neg ? YP : XP;
      else if (!x_pos && y_neg)  step = f_neg ? XM : YP;
      else                       step = f_neg ? YM : XM;
    end
  end
endmodule

// File: rtl/circular_interp.sv
// Two-axis circular interpolator: one step pulse per pulse_clk until the end point.
module circular_interp
  import circ_interp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 20
)(
  input  logic             pulse_clk,
  input  logic             sys_rst_l,
  input  logic             direct,
  input  logic [WIDTH-1:0] Xs,
  input  logic [WIDTH-1:0] Ys,
  input  logic [WIDTH-1:0] Xe,
  input  logic [WIDTH-1:0] Ye,
  input  logic             change_readyH,
  output logic             X_acc,
  output logic             Y_acc,
  output logic             X_dec,
  output logic             Y_dec,
  output logic             draw_overH
);
  localparam int FW = 2*WIDTH + 2;
  localparam logic [CNT_W-1:0]      CNT_ONE  = 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic signed [WIDTH:0] C_ONE    = 1;
  localparam logic signed [FW-1:0]  F_ONE    = 1;

  state_t                  state;
  step_t                   step;
  logic                    dir_q, at_origin;
  logic signed [WIDTH:0]   x, y, xe, ye, x_nx, y_nx;
  logic signed [FW-1:0]    f, f_nx, x_ext, y_ext;
  logic [CNT_W-1:0]        cnt;

  assign x_ext     = {{(FW-WIDTH-1){x[WIDTH]}}, x};
  assign y_ext     = {{(FW-WIDTH-1){y[WIDTH]}}, y};
  assign at_origin = (x == '0) && (y == '0);

  circ_step_sel u_sel (
    .direct (dir_q),
    .x_neg  (x[WIDTH]),
    .x_zero (x == '0),
    .y_neg  (y[WIDTH]),
    .y_zero (y == '0),
    .f_neg  (f[FW-1]),
    .step   (step)
  );

  // Deviation update uses the coordinate value before the step.
  always_comb begin
    x_nx = x;
    y_nx = y;
    f_nx = f;
    case (step)
      XP: begin f_nx = f + (x_ext <<< 1) + F_ONE; x_nx = x + C_ONE; end
      XM: begin f_nx = f - (x_ext <<< 1) + F_ONE; x_nx = x - C_ONE; end
      YP: begin f_nx = f + (y_ext <<< 1) + F_ONE; y_nx = y + C_ONE; end
      YM: begin f_nx = f - (y_ext <<< 1) + F_ONE; y_nx = y - C_ONE; end
      default: ;
    endcase
  end

  always_ff @(posedge pulse_clk) begin
    if (sys_rst_l) begin
      state      <= IDLE;
      dir_q      <= DIR_CW;
      x          <= '0;
      y          <= '0;
      xe         <= '0;
      ye         <= '0;
      f          <= '0;
      cnt        <= '0;
      X_acc      <= 1'b0;
      X_dec      <= 1'b0;
      Y_acc      <= 1'b0;
      Y_dec      <= 1'b0;
      draw_overH <= 1'b0;
    end else begin
      X_acc <= 1'b0;
      X_dec <= 1'b0;
      Y_acc <= 1'b0;
      Y_dec <= 1'b0;
      case (state)
        IDLE, DONE: begin
          draw_overH <= (state == DONE);
          if (change_readyH) begin
            dir_q      <= direct;
            x          <= {Xs[WIDTH-1], Xs};
            y          <= {Ys[WIDTH-1], Ys};
            xe         <= {Xe[WIDTH-1], Xe};
            ye         <= {Ye[WIDTH-1], Ye};
            f          <= '0;
            cnt        <= '0;
            draw_overH <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (at_origin) begin
            state <= DONE;
          end else begin
            X_acc <= (step == XP);
            X_dec <= (step == XM);
            Y_acc <= (step == YP);
            Y_dec <= (step == YM);
            x     <= x_nx;
            y     <= y_nx;
            f     <= f_nx;
            cnt   <= cnt + CNT_ONE;
            // Endpoint is only tested after a step, so start == end draws a full circle.
            if ((x_nx == xe && y_nx == ye) || cnt == CNT_LAST)
              state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_circular_interp.sv
// Randomized and directed bench for circular_interp against a radius-based reference model.
module tb_circular_interp;
  localparam int W    = 16;
  localparam int CNTW = 8;
  localparam int SAFE = (1 << CNTW) - 1;

  logic         clk = 1'b0, rst = 1'b1, direct = 1'b0, change_readyH = 1'b0;
  logic [W-1:0] Xs = '0, Ys = '0, Xe = '0, Ye = '0;
  logic         X_acc, Y_acc, X_dec, Y_dec, draw_overH;

  int n_chk = 0, n_err = 0;
  int exp_q[$], obs_q[$];
  int first_p, last_p, done_cyc;

  circular_interp #(.WIDTH(W), .CNT_W(CNTW)) dut (
    .pulse_clk(clk), .sys_rst_l(rst), .direct(direct),
    .Xs(Xs), .Ys(Ys), .Xe(Xe), .Ye(Ye), .change_readyH(change_readyH),
    .X_acc(X_acc), .Y_acc(Y_acc), .X_dec(X_dec), .Y_dec(Y_dec), .draw_overH(draw_overH)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Step codes: 0 X+, 1 X-, 2 Y+, 3 Y-, -1 none (origin).
  // Deviation is taken directly as distance-squared minus start radius-squared.
  function automatic int model_step(input bit dir, input int x, input int y, input int r2);
    bit fn;
    fn = (x*x + y*y - r2) < 0;
    if (dir) begin
      if (x > 0 && y >= 0)  return fn ? 2 : 1;
      if (x <= 0 && y > 0)  return fn ? 1 : 3;
      if (x < 0 && y <= 0)  return fn ? 3 : 0;
      if (x >= 0 && y < 0)  return fn ? 0 : 2;
    end else begin
      if (x >= 0 && y > 0)  return fn ? 0 : 3;
      if (x < 0 && y >= 0)  return fn ? 2 : 0;
      if (x <= 0 && y < 0)  return fn ? 1 : 2;
      if (x > 0 && y <= 0)  return fn ? 3 : 1;
    end
    return -1;
  endfunction

  task automatic model_run(input bit dir, input int xs, input int ys, input int xe, input int ye,
                           input int limit, output int fx, output int fy);
    int x, y, s, r2;
    x = xs; y = ys; r2 = xs*xs + ys*ys;
    exp_q.delete();
    while (!(x == 0 && y == 0)) begin
      s = model_step(dir, x, y, r2);
      exp_q.push_back(s);
      case (s)
        0: x++;
        1: x--;
        2: y++;
        default: y--;
      endcase
      if ((x == xe && y == ye) || exp_q.size() >= limit) break;
    end
    fx = x; fy = y;
  endtask

  function automatic int n_of(input int code);
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i] == code) n++;
    return n;
  endfunction

  task automatic set_in(input bit dir, input int xs, input int ys, input int xe, input int ye);
    direct = dir; Xs = xs[W-1:0]; Ys = ys[W-1:0]; Xe = xe[W-1:0]; Ye = ye[W-1:0];
  endtask

  task automatic run_arc(input bit dir, input int xs, input int ys, input int xe, input int ye,
                         input string tag, input int glitch_at);
    int fx, fy, cyc, p, bad;
    bit done;
    model_run(dir, xs, ys, xe, ye, SAFE, fx, fy);
    @(negedge clk);
    set_in(dir, xs, ys, xe, ye);
    change_readyH = 1'b1;
    @(posedge clk); #1;
    change_readyH = 1'b0;
    chk({tag, ":start"}, {draw_overH, X_acc, X_dec, Y_acc, Y_dec}, 0);
    obs_q.delete();
    cyc = 0; done = 0; first_p = 0; last_p = 0; done_cyc = 0;
    while (!done && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
      p = $countones({X_acc, X_dec, Y_acc, Y_dec});
      chk({tag, ":onehot"}, (p <= 1) && !(draw_overH && p != 0), 1);
      if (p == 1) begin
        obs_q.push_back(X_acc ? 0 : X_dec ? 1 : Y_acc ? 2 : 3);
        if (first_p == 0) first_p = cyc;
        last_p = cyc;
      end
      if (cyc == glitch_at) begin
        change_readyH = 1'b1; Xs = ~Xs; direct = ~direct;
      end else begin
        change_readyH = 1'b0;
      end
      if (draw_overH) begin done = 1; done_cyc = cyc; end
    end
    chk({tag, ":done"}, done, 1);
    chk({tag, ":npulse"}, obs_q.size(), exp_q.size());
    bad = -1;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && obs_q[i] != exp_q[i]) bad = i;
    chk({tag, ":seq_first_bad"}, bad, -1);
    if (exp_q.size() > 0) begin
      chk({tag, ":latency"}, first_p, 1);
      chk({tag, ":done_cyc"}, done_cyc, exp_q.size() + 1);
    end
  endtask

  initial begin
    int xs, ys, ex, ey, k, n;
    bit d;

    repeat (3) @(posedge clk);
    #1;
    chk("reset:outs", {draw_overH, X_acc, X_dec, Y_acc, Y_dec}, 0);
    @(negedge clk); rst = 1'b0;

    run_arc(1'b1, -10, 0, 10, 0, "half", 0);
    chk("half:first", obs_q.size() > 0 ? obs_q[0] : -1, 0);
    chk("half:second", obs_q.size() > 1 ? obs_q[1] : -1, 3);
    chk("half:x_acc", n_of(0), 20);
    chk("half:x_dec", n_of(1), 0);
    chk("half:y_acc", n_of(2), 10);
    chk("half:y_dec", n_of(3), 10);

    run_arc(1'b1, 5, 0, 5, 0, "full", 0);
    chk("full:total", obs_q.size(), 40);
    chk("full:x_acc", n_of(0), 10);
    chk("full:y_dec", n_of(3), 10);
    chk("full:end_x", 5 + n_of(0) - n_of(1), 5);
    chk("full:end_y", n_of(2) - n_of(3), 0);

    run_arc(1'b0, 0, 10, 10, 0, "cwq", 0);
    chk("cwq:first", obs_q.size() > 0 ? obs_q[0] : -1, 3);
    chk("cwq:y_dec", n_of(3), 10);
    chk("cwq:x_acc", n_of(0), 10);
    chk("cwq:total", obs_q.size(), 20);

    run_arc(1'b1, -10, 0, 10, 0, "glitch", 3);
    chk("glitch:total", obs_q.size(), 40);

    run_arc(1'b1, 0, 0, 5, 5, "origin", 0);
    chk("origin:total", obs_q.size(), 0);

    run_arc(1'b1, 5, 0, 7, 0, "safety", 0);
    chk("safety:total", obs_q.size(), SAFE);

    // Abort an arc with reset after five pulses.
    @(negedge clk);
    set_in(1'b1, -10, 0, 10, 0);
    change_readyH = 1'b1;
    @(posedge clk); #1;
    change_readyH = 1'b0;
    n = 0; k = 0;
    while (n < 5 && k < 50) begin
      @(posedge clk); #1;
      k++;
      n += $countones({X_acc, X_dec, Y_acc, Y_dec});
    end
    chk("rst:five", n, 5);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst:outs", {draw_overH, X_acc, X_dec, Y_acc, Y_dec}, 0);
    @(negedge clk); rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n += $countones({draw_overH, X_acc, X_dec, Y_acc, Y_dec});
    end
    chk("rst:idle", n, 0);

    for (int t = 0; t < 10; t++) begin
      xs = int'($urandom_range(0, 40)) - 20;
      ys = int'($urandom_range(0, 40)) - 20;
      d  = 1'($urandom_range(0, 1));
      k  = int'($urandom_range(1, 60));
      model_run(d, xs, ys, 100000, 100000, k, ex, ey);
      run_arc(d, xs, ys, ex, ey, $sformatf("rnd%0d", t), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
